mem_req_arbiter: RTL and testbench

- N-channel arbiter merging several core-side memory request/response ports onto the single cache request port driven into cache_controller.
- Round-robin arbitration feeds one registered request stage.
- Read responses are routed back to the issuing channel via an in-order tag FIFO.
- Used by the next test/top level to share one cache between instruction fetch, load/store and loader ports.

---
 rtl/mem_req_arbiter_if.sv | 39 +++
 rtl/mem_req_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Bus bundle for mem_req_arbiter: core-side channel ports and
// the single cache-side request/response port.
interface mem_req_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
);
  logic [NUM_CH*ADDR_W-1:0] ch_req_addr;
  logic [NUM_CH*DATA_W-1:0] ch_req_data;
  logic [NUM_CH-1:0]        ch_req_wr;
  logic [NUM_CH-1:0]        ch_req_valid;
  logic [NUM_CH-1:0]        ch_req_ready;
  logic [NUM_CH*DATA_W-1:0] ch_rsp_data;
  logic [NUM_CH-1:0]        ch_rsp_valid;
  logic [ADDR_W-1:0]        mem_req_addr;
  logic [DATA_W-1:0]        mem_req_data;
  logic                     mem_req_wr;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [DATA_W-1:0]        mem_rsp_data;
  logic                     mem_rsp_valid;
  logic                     rsp_err;

  modport master (
    output ch_req_addr, ch_req_data, ch_req_wr, ch_req_valid,
    output mem_req_ready, mem_rsp_data, mem_rsp_valid,
    input  ch_req_ready, ch_rsp_data, ch_rsp_valid,
    input  mem_req_addr, mem_req_data, mem_req_wr, mem_req_valid,
    input  rsp_err
  );

  modport slave (
    input  ch_req_addr, ch_req_data, ch_req_wr, ch_req_valid,
    input  mem_req_ready, mem_rsp_data, mem_rsp_valid,
    output ch_req_ready, ch_rsp_data, ch_rsp_valid,
    output mem_req_addr, mem_req_data, mem_req_wr, mem_req_valid,
    output rsp_err
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// N-channel round-robin arbiter onto one registered cache request port.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mem_req_arbiter #(
  parameter int NUM_CH          = 2,
  parameter int ADDR_W          = 25,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic reset,
  mem_req_arbiter_if.slave bus
);
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = AW + 1;

  logic [ADDR_W-1:0]        r_addr;
  logic [DATA_W-1:0]        r_data;
  logic                     r_wr;
  logic                     r_valid;
  logic [NUM_CH*DATA_W-1:0] r_rsp_data;
  logic [NUM_CH-1:0]        r_rsp_valid;
  logic                     r_err;
  logic [AW-1:0]            r_wp;
  logic [AW-1:0]            r_rp;
  logic [CW-1:0]            r_cnt;
  logic [PW-1:0]            r_tag [MAX_OUTSTANDING];

  logic              w_full;
  logic              w_empty;
  logic [NUM_CH-1:0] w_elig;
  logic              w_any;
  logic [PW-1:0]     w_g;
  logic              w_load;
  logic              w_hs;
  logic              w_push;
  logic              w_pop;
  logic [PW-1:0]     w_head;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [PW-1:0] r_rr;
  logic [PW:0]   w_sum;
`endif

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(MAX_OUTSTANDING));
  assign w_elig  = bus.ch_req_valid &
                   (bus.ch_req_wr | {NUM_CH{~w_full}});
  assign w_load  = ~r_valid | bus.mem_req_ready;
  assign w_hs    = w_load & w_any;
  assign w_push  = w_hs & ~bus.ch_req_wr[w_g];
  assign w_pop   = bus.mem_rsp_valid & ~w_empty;
  assign w_head  = r_tag[r_rp];

  assign bus.ch_req_ready  = w_hs ? (NUM_CH'(1) << w_g) : '0;
  assign bus.mem_req_addr  = r_addr;
  assign bus.mem_req_data  = r_data;
  assign bus.mem_req_wr    = r_wr;
  assign bus.mem_req_valid = r_valid;
  assign bus.ch_rsp_data   = r_rsp_data;
  assign bus.ch_rsp_valid  = r_rsp_valid;
  assign bus.rsp_err       = r_err;

  // Grant select: lowest scan offset with an eligible channel wins
  always_comb begin
    w_any = 1'b0;
    w_g   = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_any = 1'b1;
        w_g   = PW'(i);
      end
    end
`else
    w_sum = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NUM_CH))
        w_sum = w_sum - (PW+1)'(NUM_CH);
      if (w_elig[w_sum[PW-1:0]]) begin
        w_any = 1'b1;
        w_g   = w_sum[PW-1:0];
      end
    end
`endif
  end

`ifndef MEM_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves just past the last granted channel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_rr <= '0;
    else if (w_hs)
      r_rr <= (w_g == PW'(NUM_CH - 1)) ? '0 : w_g + 1'b1;
  end
`endif

  // Output request register, reloaded whenever it is free or draining
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_addr <= bus.ch_req_addr[w_g*ADDR_W +: ADDR_W];
        r_data <= bus.ch_req_data[w_g*DATA_W +: DATA_W];
        r_wr   <= bus.ch_req_wr[w_g];
      end
    end
  end

  // Tag storage holds the issuing channel of each outstanding read
  always_ff @(posedge clk) begin
    if (w_push)
      r_tag[r_wp] <= w_g;
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Route the response to the tagged channel; flag orphan responses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= w_pop ? (NUM_CH'(1) << w_head) : '0;
      if (w_pop)
        r_rsp_data[w_head*DATA_W +: DATA_W] <= bus.mem_rsp_data;
      if (bus.mem_rsp_valid && w_empty)
        r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_mem_req_arbiter;
  localparam int NCH = 2;
  localparam int AW  = 25;
  localparam int DW  = 32;
  localparam int MO  = 4;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
  } req_t;

  typedef struct {
    int            ch;
    logic [DW-1:0] d;
    int            due;
  } rsp_t;

  logic clk;
  logic rst_n;
  int   tick;
  int   n_cmp;
  int   n_fail;
  int   dn_issued;
  int   dn_done;

  req_t exp_req [$];
  rsp_t exp_rsp [$];
  int   tags [$];

  bit            m_v;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d;
  logic          m_w;
  int            m_ptr;
  bit            m_err;
  int            m_g;

  mem_req_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) ifc ();

  mem_req_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial tick = 0;
  always @(posedge clk) tick <= tick + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [NCH-1:0] v, input logic [NCH-1:0] w,
                     input logic [NCH*AW-1:0] a,
                     input logic [NCH*DW-1:0] d,
                     input logic mr, input logic rv,
                     input logic [DW-1:0] rd);
    logic [NCH-1:0] erdy;
    bit   full;
    bit   load;
    int   g;
    rsp_t r;
    @(negedge clk);
    ifc.ch_req_valid  = v;
    ifc.ch_req_wr     = w;
    ifc.ch_req_addr   = a;
    ifc.ch_req_data   = d;
    ifc.mem_req_ready = mr;
    ifc.mem_rsp_valid = rv;
    ifc.mem_rsp_data  = rd;
    #1;
    chk("mem_req_valid", 64'(ifc.mem_req_valid), 64'(m_v));
    chk("rsp_err", 64'(ifc.rsp_err), 64'(m_err));
    if (m_v) begin
      chk("stage_addr", 64'(ifc.mem_req_addr), 64'(m_a));
      chk("stage_data", 64'(ifc.mem_req_data), 64'(m_d));
      chk("stage_wr", 64'(ifc.mem_req_wr), 64'(m_w));
    end
    full = tags.size() >= MO;
    load = !m_v || mr;
    g = -1;
    for (int k = 0; k < NCH; k++) begin
      int i;
`ifdef MEM_ARB_FIXED_PRIO_EN
      i = k;
`else
      i = (m_ptr + k) % NCH;
`endif
      if (g < 0 && v[i] && (w[i] || !full))
        g = i;
    end
    if (!load)
      g = -1;
    erdy = (g >= 0) ? (NCH'(1) << g) : '0;
    chk("ch_req_ready", 64'(ifc.ch_req_ready), 64'(erdy));
    if (rv) begin
      if (tags.size() == 0) begin
        m_err = 1'b1;
      end else begin
        r.ch  = tags.pop_front();
        r.d   = rd;
        r.due = tick + 1;
        exp_rsp.push_back(r);
        dn_done++;
      end
    end
    if (g >= 0) begin
      m_a = a[g*AW +: AW];
      m_d = d[g*DW +: DW];
      m_w = w[g];
      if (!w[g])
        tags.push_back(g);
      exp_req.push_back('{m_a, m_d, m_w});
      m_v   = 1'b1;
      m_ptr = (g + 1) % NCH;
    end else if (load) begin
      m_v = 1'b0;
    end
    m_g = g;
  endtask

  task automatic one(input int ch, input logic w,
                     input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic mr, input logic rv,
                     input logic [DW-1:0] rd);
    logic [NCH-1:0]    vv;
    logic [NCH-1:0]    ww;
    logic [NCH*AW-1:0] aa;
    logic [NCH*DW-1:0] dd;
    vv = '0;
    ww = '0;
    aa = '0;
    dd = '0;
    vv[ch] = 1'b1;
    ww[ch] = w;
    aa[ch*AW +: AW] = a;
    dd[ch*DW +: DW] = d;
    cyc(vv, ww, aa, dd, mr, rv, rd);
  endtask

  task automatic idle(input logic mr, input logic rv,
                      input logic [DW-1:0] rd);
    cyc('0, '0, '0, '0, mr, rv, rd);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((tags.size() != 0 || m_v || exp_req.size() != 0 ||
            exp_rsp.size() != 0) && b < 300) begin
      idle(1'b1, dn_issued > dn_done, $urandom);
      b++;
    end
    idle(1'b1, 1'b0, '0);
    idle(1'b1, 1'b0, '0);
    chk("drain_req_left", 64'(exp_req.size()), 64'd0);
    chk("drain_rsp_left", 64'(exp_rsp.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifc.ch_req_valid  = '0;
    ifc.ch_req_wr     = '0;
    ifc.ch_req_addr   = '0;
    ifc.ch_req_data   = '0;
    ifc.mem_req_ready = 1'b0;
    ifc.mem_rsp_valid = 1'b0;
    ifc.mem_rsp_data  = '0;
    #1;
    chk("rst_mem_req_valid", 64'(ifc.mem_req_valid), 64'd0);
    chk("rst_mem_req_addr", 64'(ifc.mem_req_addr), 64'd0);
    chk("rst_mem_req_data", 64'(ifc.mem_req_data), 64'd0);
    chk("rst_mem_req_wr", 64'(ifc.mem_req_wr), 64'd0);
    chk("rst_ch_rsp_valid", 64'(ifc.ch_rsp_valid), 64'd0);
    chk("rst_ch_rsp_data", 64'(ifc.ch_rsp_data), 64'd0);
    chk("rst_rsp_err", 64'(ifc.rsp_err), 64'd0);
    tags.delete();
    exp_req.delete();
    exp_rsp.delete();
    m_v   = 1'b0;
    m_a   = '0;
    m_d   = '0;
    m_w   = 1'b0;
    m_ptr = 0;
    m_err = 1'b0;
    m_g   = -1;
    dn_done = dn_issued;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rnd_phase(input int n);
    logic [NCH-1:0]    pv;
    logic [NCH-1:0]    pw;
    logic [NCH*AW-1:0] pa;
    logic [NCH*DW-1:0] pd;
    logic              rv;
    pv = '0;
    pw = '0;
    pa = '0;
    pd = '0;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 45) begin
          pv[i] = 1'b1;
          pw[i] = ($urandom_range(0, 2) == 0);
          pa[i*AW +: AW] = AW'($urandom);
          pd[i*DW +: DW] = $urandom;
        end
      end
      rv = (dn_issued > dn_done) && ($urandom_range(0, 1) == 1);
      cyc(pv, pw, pa, pd, $urandom_range(0, 3) != 0, rv, $urandom);
      if (m_g >= 0)
        pv[m_g] = 1'b0;
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents traffic
  initial begin
    req_t e;
    rsp_t r;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (ifc.mem_req_valid && ifc.mem_req_ready) begin
          if (exp_req.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL mem_req_unexpected: got addr %0h want none",
                     ifc.mem_req_addr);
          end else begin
            e = exp_req.pop_front();
            chk("mem_req_addr", 64'(ifc.mem_req_addr), 64'(e.a));
            chk("mem_req_data", 64'(ifc.mem_req_data), 64'(e.d));
            chk("mem_req_wr", 64'(ifc.mem_req_wr), 64'(e.w));
            if (!ifc.mem_req_wr)
              dn_issued++;
          end
        end
        if (|ifc.ch_rsp_valid) begin
          if (exp_rsp.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ch_rsp_unexpected: got valid %0h want 0",
                     ifc.ch_rsp_valid);
          end else begin
            r = exp_rsp.pop_front();
            chk("ch_rsp_valid", 64'(ifc.ch_rsp_valid),
                64'(NCH'(1) << r.ch));
            chk("ch_rsp_data", 64'(ifc.ch_rsp_data[r.ch*DW +: DW]),
                64'(r.d));
            chk("ch_rsp_latency", 64'(tick), 64'(r.due));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    dn_issued = 0;
    dn_done   = 0;
    rst_n     = 1'b0;
    ifc.ch_req_valid  = '0;
    ifc.ch_req_wr     = '0;
    ifc.ch_req_addr   = '0;
    ifc.ch_req_data   = '0;
    ifc.mem_req_ready = 1'b0;
    ifc.mem_rsp_valid = 1'b0;
    ifc.mem_rsp_data  = '0;
    do_reset();

    one(0, 1'b0, 25'h000100, '0, 1'b1, 1'b0, '0);
    idle(1'b1, 1'b0, '0);
    idle(1'b1, 1'b0, '0);
    idle(1'b1, 1'b1, 32'hDEADBEEF);
    idle(1'b1, 1'b0, '0);
    drain();

    do_reset();
    for (int k = 0; k < 4; k++)
      cyc(2'b11, 2'b00, {25'(k + 16), 25'(k)}, '0,
          1'b1, 1'b0, '0);
    drain();

    one(0, 1'b1, 25'h1ABCDEF, 32'h12345678, 1'b1, 1'b0, '0);
    for (int k = 0; k < 5; k++)
      one(1, 1'b0, 25'h000222, '0, 1'b0, 1'b0, '0);
    one(1, 1'b0, 25'h000222, '0, 1'b1, 1'b0, '0);
    drain();

    for (int k = 0; k < 4; k++)
      one(0, 1'b0, 25'(k + 32'h40), '0, 1'b1, 1'b0, '0);
    cyc(2'b11, 2'b10, {25'h0000A0, 25'h000050}, {32'h11, 32'h0},
        1'b1, 1'b0, '0);
    cyc(2'b11, 2'b10, {25'h0000A4, 25'h000050}, {32'h22, 32'h0},
        1'b1, 1'b0, '0);
    one(0, 1'b0, 25'h000050, '0, 1'b1, 1'b1, 32'h55);
    one(0, 1'b0, 25'h000050, '0, 1'b1, 1'b0, '0);
    drain();

    one(1, 1'b0, 25'h000301, '0, 1'b1, 1'b0, '0);
    one(0, 1'b0, 25'h000302, '0, 1'b1, 1'b0, '0);
    one(1, 1'b0, 25'h000303, '0, 1'b1, 1'b0, '0);
    idle(1'b1, 1'b0, '0);
    idle(1'b1, 1'b1, 32'hA);
    idle(1'b1, 1'b1, 32'hB);
    idle(1'b1, 1'b1, 32'hC);
    drain();

    idle(1'b1, 1'b1, 32'hBAD);
    idle(1'b1, 1'b0, '0);
    idle(1'b1, 1'b0, '0);

    rnd_phase(1500);
    do_reset();
    rnd_phase(600);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end
endmodule
